turn_move_engine: RTL and testbench
===================================

TURN_MOVE_ENGINE -- requirements
Module: turn_move_engine

Interface
REQ-001 Parameters: none; the board has 16 cells (0..15), fixed 4-bit positions.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn1  input  1  player-2 advance request (move toward cell 0); level, synchronous to clk.
REQ-005 btn2  input  1  player-2 retreat request (move toward cell 15); level, synchronous to clk.
REQ-006 btn3  input  1  player-1 advance request (move toward cell 15); level, synchronous to clk.
REQ-007 btn4  input  1  player-1 retreat request (move toward cell 0); level, synchronous to clk.
REQ-008 pos1  output  4  player-1 cell, registered.
REQ-009 pos2  output  4  player-2 cell, registered.
REQ-010 step  output  2  current move distance from the turn sequence (0..3).
REQ-011 active  output  1  0 = player 1 to move, 1 = player 2 to move.
REQ-012 led  output  16  bit k = 1 iff pos1==k or pos2==k; combinational from pos1/pos2.
REQ-013 game_over  output  1  high once a player has won; sticky until rst.
REQ-014 winner  output  1  0 = player 1 won, 1 = player 2 won; meaningful only when game_over=1, 0 otherwise.

Function
REQ-015 Each button is edge-detected: a request fires in cycle N iff the button is 1 in N and was 1'b0 in N-1; a held button fires once.
REQ-016 The previous-value register of every button resets to 1, so a button held through reset does not fire on release of rst.
REQ-017 Only the active player's buttons are accepted; the opponent's edges are ignored with no state change.
REQ-018 If both buttons of the active player fire in the same cycle, advance wins and retreat is discarded.
REQ-019 The step sequence is 1,2,3,3,2,1,0, then it repeats from 1; a 3-bit index 0..6 selects the entry, and the index wraps 6->0.
REQ-020 Player-1 advance target = min(pos1+step, 15); player-1 retreat target = max(pos1-1, 0); use 5-bit intermediate arithmetic and saturate, never wrap.
REQ-021 Player-2 advance target = max(pos2-step, 0); player-2 retreat target = min(pos2+1, 15).
REQ-022 Collision rule: if the target equals the opponent's current position, the move is blocked and the mover's position is unchanged.
REQ-023 Every accepted request, including a blocked, zero-step or saturated one, consumes the turn: active toggles and the step index advances.
REQ-024 Latency: a request fired in cycle N updates pos, active and step at the rising edge ending cycle N, so new values are visible in N+1.
REQ-025 The win is checked on the registered positions: pos1==15 sets game_over=1 and winner=0; pos2==0 sets game_over=1 and winner=1; both are set in the same cycle as the winning move.
REQ-026 While game_over=1, all requests are ignored and pos1, pos2, step and active hold their values.
REQ-027 led has exactly two bits set when pos1!=pos2; positions never coincide because of REQ-022.

Reset
REQ-028 While rst=1 at a rising edge, the block sets: pos1=0, pos2=15, step index=0 (step=1), active=0, game_over=0, winner=0, button-history registers=1.
REQ-029 rst overrides any request fired in the same cycle; reset mid-game fully restarts the game.

Verification
REQ-030 Release rst -> pos1=0, pos2=15, step=1, active=0, led=16'h8001, game_over=0.
REQ-031 btn3 rising edge -> next cycle pos1=1, active=1, step=2; then btn1 edge -> pos2=13, active=0, step=3.
REQ-032 While active=0, pulse btn1 and btn2 -> no change in any output; hold btn3 high for 5 cycles -> exactly one move.
REQ-033 Collision: pos1=5, pos2=7, step=2, active=0, btn3 edge -> pos1 stays 5, active=1, step index advances.
REQ-034 Saturation: pos2=15, active=1, btn2 edge -> pos2 stays 15, turn passes; pos1=14, step=3, btn3 edge with pos2!=15 -> pos1=15, game_over=1, winner=0, and later buttons are ignored.
REQ-035 Step wrap: make 7 accepted moves from reset -> the step output sequence is 1,2,3,3,2,1,0 and then returns to 1.

Source files
------------

// File: rtl/turn_move_engine.sv
// Two-player race on a 16-cell strip: players alternate turns, advance by a
// cyclic step distance or retreat by one, and win on reaching the far end.
module turn_move_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn1,
  input  logic        btn2,
  input  logic        btn3,
  input  logic        btn4,
  output logic [3:0]  pos1,
  output logic [3:0]  pos2,
  output logic [1:0]  step,
  output logic        active,
  output logic [15:0] led,
  output logic        game_over,
  output logic        winner
);

  logic [3:0] r_pos1;
  logic [3:0] r_pos2;
  logic [2:0] r_stepIdx;
  logic       r_active;
  logic       r_gameOver;
  logic       r_winner;
  logic [3:0] r_btnPrev;

  logic [3:0] w_btn;
  logic [3:0] w_fire;
  logic [1:0] w_step;
  logic [4:0] w_p1Sum;
  logic [4:0] w_p2Diff;
  logic [3:0] w_p1AdvTgt;
  logic [3:0] w_p1RetTgt;
  logic [3:0] w_p2AdvTgt;
  logic [3:0] w_p2RetTgt;
  logic [3:0] w_target;
  logic       w_request;
  logic [3:0] w_nextPos1;
  logic [3:0] w_nextPos2;
  logic [2:0] w_nextStepIdx;
  logic       w_nextActive;
  logic       w_nextGameOver;
  logic       w_nextWinner;

  // Bit order {btn4, btn3, btn2, btn1}; a request is a 0->1 transition.
  assign w_btn  = {btn4, btn3, btn2, btn1};
  assign w_fire = w_btn & ~r_btnPrev;

  always_comb begin
    w_step = 2'd1;
    case (r_stepIdx)
      3'd0:    w_step = 2'd1;
      3'd1:    w_step = 2'd2;
      3'd2:    w_step = 2'd3;
      3'd3:    w_step = 2'd3;
      3'd4:    w_step = 2'd2;
      3'd5:    w_step = 2'd1;
      3'd6:    w_step = 2'd0;
      default: w_step = 2'd1;
    endcase
  end

  // Five-bit sums so overflow past 15 and underflow below 0 saturate instead of wrapping.
  assign w_p1Sum    = {1'b0, r_pos1} + {3'b000, w_step};
  assign w_p2Diff   = {1'b0, r_pos2} - {3'b000, w_step};
  assign w_p1AdvTgt = (w_p1Sum > 5'd15) ? 4'd15 : w_p1Sum[3:0];
  assign w_p1RetTgt = (r_pos1 == 4'd0) ? 4'd0 : r_pos1 - 4'd1;
  assign w_p2AdvTgt = w_p2Diff[4] ? 4'd0 : w_p2Diff[3:0];
  assign w_p2RetTgt = (r_pos2 == 4'd15) ? 4'd15 : r_pos2 + 4'd1;

  always_comb begin
    w_request      = 1'b0;
    w_target       = r_pos1;
    w_nextPos1     = r_pos1;
    w_nextPos2     = r_pos2;
    w_nextStepIdx  = r_stepIdx;
    w_nextActive   = r_active;
    w_nextGameOver = r_gameOver;
    w_nextWinner   = r_winner;
    if (!r_gameOver) begin
      if (!r_active) begin
        w_target = r_pos1;
        if (w_fire[2]) begin
          w_request = 1'b1;
          w_target  = w_p1AdvTgt;
        end else if (w_fire[3]) begin
          w_request = 1'b1;
          w_target  = w_p1RetTgt;
        end
        if (w_request && (w_target != r_pos2))
          w_nextPos1 = w_target;
      end else begin
        w_target = r_pos2;
        if (w_fire[0]) begin
          w_request = 1'b1;
          w_target  = w_p2AdvTgt;
        end else if (w_fire[1]) begin
          w_request = 1'b1;
          w_target  = w_p2RetTgt;
        end
        if (w_request && (w_target != r_pos1))
          w_nextPos2 = w_target;
      end
      // Blocked and zero-length moves still hand the turn over.
      if (w_request) begin
        w_nextActive  = ~r_active;
        w_nextStepIdx = (r_stepIdx == 3'd6) ? 3'd0 : r_stepIdx + 3'd1;
      end
      if (w_nextPos1 == 4'd15) begin
        w_nextGameOver = 1'b1;
        w_nextWinner   = 1'b0;
      end else if (w_nextPos2 == 4'd0) begin
        w_nextGameOver = 1'b1;
        w_nextWinner   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos1     <= 4'd0;
      r_pos2     <= 4'd15;
      r_stepIdx  <= 3'd0;
      r_active   <= 1'b0;
      r_gameOver <= 1'b0;
      r_winner   <= 1'b0;
      r_btnPrev  <= 4'b1111;
    end else begin
      r_pos1     <= w_nextPos1;
      r_pos2     <= w_nextPos2;
      r_stepIdx  <= w_nextStepIdx;
      r_active   <= w_nextActive;
      r_gameOver <= w_nextGameOver;
      r_winner   <= w_nextWinner;
      r_btnPrev  <= w_btn;
    end
  end

  assign pos1      = r_pos1;
  assign pos2      = r_pos2;
  assign step      = w_step;
  assign active    = r_active;
  assign game_over = r_gameOver;
  assign winner    = r_winner;
  assign led       = (16'h0001 << r_pos1) | (16'h0001 << r_pos2);

endmodule

// File: tb/tb_turn_move_engine.sv
// Directed bench for turn_move_engine: walks two hand-planned games and checks
// every output after each button event against hand-computed positions.
module tb_turn_move_engine;

  logic        clock;
  logic        rst;
  logic        btn1, btn2, btn3, btn4;
  logic [3:0]  pos1, pos2;
  logic [1:0]  step;
  logic        active;
  logic [15:0] led;
  logic        gameOver;
  logic        winner;

  int testsRun;
  int testsFailed;

  turn_move_engine dut (
    .clk       (clock),
    .rst       (rst),
    .btn1      (btn1),
    .btn2      (btn2),
    .btn3      (btn3),
    .btn4      (btn4),
    .pos1      (pos1),
    .pos2      (pos2),
    .step      (step),
    .active    (active),
    .led       (led),
    .game_over (gameOver),
    .winner    (winner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled on the falling edge, half a cycle after the update.
  task automatic checkOutput(input string tag, input logic [3:0] eP1, input logic [3:0] eP2,
                             input logic [1:0] eStep, input logic eAct, input logic eGo,
                             input logic eWin);
    logic [15:0] expLed;
    expLed = (16'h0001 << eP1) | (16'h0001 << eP2);
    compare({tag, ".pos1"},   {12'h0, pos1},     {12'h0, eP1});
    compare({tag, ".pos2"},   {12'h0, pos2},     {12'h0, eP2});
    compare({tag, ".step"},   {14'h0, step},     {14'h0, eStep});
    compare({tag, ".active"}, {15'h0, active},   {15'h0, eAct});
    compare({tag, ".led"},    led,               expLed);
    compare({tag, ".gover"},  {15'h0, gameOver}, {15'h0, eGo});
    compare({tag, ".winner"}, {15'h0, winner},   {15'h0, eWin});
  endtask

  // mask = {btn4, btn3, btn2, btn1}, high for exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] mask);
    @(negedge clock);
    {btn4, btn3, btn2, btn1} = mask;
    @(negedge clock);
    {btn4, btn3, btn2, btn1} = 4'b0000;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst  = 1'b1;
    btn1 = 1'b0;
    btn2 = 1'b0;
    btn3 = 1'b1;
    btn4 = 1'b0;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checkOutput("reset", 4'd0, 4'd15, 2'd1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("heldThroughReset", 4'd0, 4'd15, 2'd1, 1'b0, 1'b0, 1'b0);
    btn3 = 1'b0;

    applyStimulus(4'b0100); checkOutput("m1", 4'd1, 4'd15, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("m2", 4'd1, 4'd13, 2'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("ignoreBtn1", 4'd1, 4'd13, 2'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("ignoreBtn2", 4'd1, 4'd13, 2'd3, 1'b0, 1'b0, 1'b0);

    @(negedge clock);
    btn3 = 1'b1;
    repeat (5) @(negedge clock);
    btn3 = 1'b0;
    checkOutput("holdBtn3", 4'd4, 4'd13, 2'd3, 1'b1, 1'b0, 1'b0);

    applyStimulus(4'b0001); checkOutput("m4", 4'd4, 4'd10, 2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000); checkOutput("m5", 4'd3, 4'd10, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("m6", 4'd3, 4'd9,  2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("m7zeroStep", 4'd3, 4'd9, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("m8", 4'd3, 4'd8,  2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1100); checkOutput("m9bothBtns", 4'd5, 4'd8, 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("m10p2Blocked", 4'd5, 4'd8, 2'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000); checkOutput("m11", 4'd4, 4'd8,  2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("m12", 4'd4, 4'd9,  2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("m13", 4'd5, 4'd9,  2'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("m14", 4'd5, 4'd9,  2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("m15", 4'd6, 4'd9,  2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("m16", 4'd6, 4'd10, 2'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000); checkOutput("m17", 4'd5, 4'd10, 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("m18", 4'd5, 4'd7,  2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("m19p1Blocked", 4'd5, 4'd7, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("ignoreBtn3", 4'd5, 4'd7, 2'd1, 1'b1, 1'b0, 1'b0);

    // Reset asserted alongside a valid request: reset must win.
    @(negedge clock);
    rst  = 1'b1;
    btn1 = 1'b1;
    @(negedge clock);
    rst  = 1'b0;
    btn1 = 1'b0;
    checkOutput("midReset", 4'd0, 4'd15, 2'd1, 1'b0, 1'b0, 1'b0);

    applyStimulus(4'b0100); checkOutput("r1",  4'd1,  4'd15, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("r2sat", 4'd1, 4'd15, 2'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("r3",  4'd4,  4'd15, 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("r4",  4'd4,  4'd15, 2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("r5",  4'd6,  4'd15, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("r6",  4'd6,  4'd15, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("r7",  4'd6,  4'd15, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("r8",  4'd6,  4'd15, 2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("r9",  4'd8,  4'd15, 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("r10", 4'd8,  4'd15, 2'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("r11", 4'd11, 4'd15, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("r12", 4'd11, 4'd13, 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("r13", 4'd12, 4'd13, 2'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkOutput("r14", 4'd12, 4'd14, 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("r15", 4'd13, 4'd14, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkOutput("r16", 4'd13, 4'd12, 2'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkOutput("r17win", 4'd15, 4'd12, 2'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0001); checkOutput("overBtn1", 4'd15, 4'd12, 2'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0010); checkOutput("overBtn2", 4'd15, 4'd12, 2'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b1100); checkOutput("overP1", 4'd15, 4'd12, 2'd3, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
